// File: rtl/itemporal_gen.sv
// Binary-to-unary temporal encoder: each operand becomes a W-bit thermometer burst plus sign.
// First bit one edge after accept; en low stalls everything, i_ready only at idle or on a window's last bit.
module itemporal_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_data_sign,
  output logic             o_data_dff,
  output logic             o_busy,
  output logic             o_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int               W       = 1 << (WIDTH - 1);
  localparam logic [WIDTH-1:0] W_L     = WIDTH'(W);
  localparam logic [WIDTH-1:0] WIN_ONE = WIDTH'(1);
  localparam logic [WIDTH-2:0] MAG_ONE = (WIDTH - 1)'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] win;
  logic [WIDTH-2:0] mag;

  logic             sign;
  logic [WIDTH-2:0] neg;
  logic [WIDTH-2:0] m;
  logic             accept;

  // The most negative value has no positive twin, so it saturates to W-1.
  always_comb begin
    sign = i_data[WIDTH-1];
    neg  = -i_data[WIDTH-2:0];
    if (i_data == MIN_NEG) begin
      m = '1;
    end else if (sign) begin
      m = neg;
    end else begin
      m = i_data[WIDTH-2:0];
    end
  end

  assign i_ready = en & ~clr & ~rst &
                   ((state == IDLE) | ((state == RUN) & (win == W_L)));
  assign accept  = i_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state       <= IDLE;
      win         <= '0;
      mag         <= '0;
      o_data_sign <= 1'b0;
      o_data_dff  <= 1'b0;
      o_busy      <= 1'b0;
      o_last      <= 1'b0;
    end else if (en) begin
      if (accept) begin
        // A new window may start on the last bit of the previous one: no gap bit.
        state       <= RUN;
        o_data_sign <= sign;
        o_data_dff  <= (m != '0);
        mag         <= (m != '0) ? (m - MAG_ONE) : '0;
        win         <= WIN_ONE;
        o_busy      <= 1'b1;
        o_last      <= (W == 1);
      end else if (state == RUN) begin
        if (win != W_L) begin
          o_data_dff <= (mag != '0);
          if (mag != '0) begin
            mag <= mag - MAG_ONE;
          end
          win    <= win + WIN_ONE;
          o_last <= ((win + WIN_ONE) == W_L);
        end else begin
          state       <= IDLE;
          win         <= '0;
          mag         <= '0;
          o_data_sign <= 1'b0;
          o_data_dff  <= 1'b0;
          o_busy      <= 1'b0;
          o_last      <= 1'b0;
        end
      end
    end
  end

endmodule
